// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal transmit FIFO.
// Words arrive on a valid/ready stream and are buffered. Each word is sent
// LSB-first as start, data, optional parity and one or two stop bits.
// The baud rate is a clock-enable counter inside the clk domain.
// Queued frames follow each other with no idle gap on tx.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic                          s_valid,
    input  logic [DATA_BITS-1:0]          s_data,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // A divisor below 2 is raised to 2.
    function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    // The parity bit for the latched mode. 01 selects even parity and 10 selects odd parity.
    function automatic logic parity_bit(input logic [1:0] mode, input logic xor_all);
        return (mode == 2'b01) ? xor_all : ~xor_all;
    endfunction

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 push, pop, fifo_empty;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     baud_cnt_q, div_q, eff_div;
    logic [1:0]           par_mode_q;
    logic                 two_stop_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [1:0]           stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 bit_end, stop_last, par_en, last_data;

    assign s_ready    = (count_q != CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = s_valid && s_ready;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE);

    assign eff_div    = sat_div(div_q);
    assign bit_end    = (state_q != IDLE) && (baud_cnt_q == eff_div - DIV_W'(1));
    assign stop_last  = !two_stop_q || (stop_cnt_q == 2'd2);
    assign par_en     = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
    assign last_data  = (bit_cnt_q == BW'(DATA_BITS));

    // Next-state logic. A pop happens on every edge that starts a frame.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end && last_data) state_d = par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end && stop_last) begin
                    if (!fifo_empty) begin
                        state_d = START;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers and occupancy. A push and a pop on the same edge leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // FIFO storage. The data words are not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= s_data;
    end

    // State register, baud, bit and stop counters, latched configuration and the registered tx line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            div_q      <= '0;
            par_mode_q <= '0;
            two_stop_q <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state_q <= state_d;
            if (pop) begin
                baud_cnt_q <= '0;
                bit_cnt_q  <= '0;
                stop_cnt_q <= '0;
                div_q      <= baud_div;
                par_mode_q <= parity_mode;
                two_stop_q <= two_stop;
                tx         <= 1'b0;
            end else if (state_q == IDLE) begin
                baud_cnt_q <= '0;
                tx         <= 1'b1;
            end else if (!bit_end) begin
                baud_cnt_q <= baud_cnt_q + DIV_W'(1);
            end else begin
                baud_cnt_q <= '0;
                case (state_q)
                    START: begin
                        tx        <= shift_q[0];
                        bit_cnt_q <= BW'(1);
                    end
                    DATA: begin
                        if (last_data) begin
                            if (par_en) begin
                                tx <= parity_bit(par_mode_q, par_q);
                            end else begin
                                tx         <= 1'b1;
                                stop_cnt_q <= 2'd1;
                            end
                        end else begin
                            tx        <= shift_q[0];
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                    PARITY: begin
                        tx         <= 1'b1;
                        stop_cnt_q <= 2'd1;
                    end
                    STOP: begin
                        tx <= 1'b1;
                        if (!stop_last) stop_cnt_q <= 2'd2;
                    end
                    default: tx <= 1'b1;
                endcase
            end
        end
    end

    // Shift register and data parity. These load on the pop edge, and the shift register moves once per data bit sent.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_q <= mem[rd_ptr_q];
            par_q   <= ^mem[rd_ptr_q];
        end else if (bit_end && ((state_q == START) || ((state_q == DATA) && !last_data))) begin
            shift_q <= shift_q >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Random traffic and configuration are compared
// cycle by cycle against a frame-level model. The model keeps a queue of
// accepted words and the expected bit list of the frame in flight.
module tb_uart_tx_fifo;

    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [DIV_W-1:0]     baud_div;
    logic [1:0]           parity_mode;
    logic                 two_stop;
    logic                 s_valid;
    logic [DATA_BITS-1:0] s_data;
    logic                 s_ready;
    logic                 tx;
    logic                 busy;
    logic [CW-1:0]        fifo_count;

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DIV_W     (DIV_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // The reference model: a word queue plus the expected bit list of the current frame.
    logic [DATA_BITS-1:0] mq[$];
    bit                   fbits[$];
    int                   m_eff, m_fc, m_len;
    bit                   m_active;

    task automatic start_frame();
        logic [DATA_BITS-1:0] w;
        w = mq.pop_front();
        m_eff = (baud_div < 2) ? 2 : int'(baud_div);
        fbits.delete();
        fbits.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) fbits.push_back(w[i]);
        if (parity_mode == 2'b01) fbits.push_back(^w);
        if (parity_mode == 2'b10) fbits.push_back(~^w);
        fbits.push_back(1'b1);
        if (two_stop) fbits.push_back(1'b1);
        m_len    = fbits.size() * m_eff;
        m_fc     = 0;
        m_active = 1'b1;
    endtask

    task automatic model_edge();
        bit had_word, do_push;
        had_word = (mq.size() != 0);
        do_push  = s_valid && (mq.size() < FIFO_DEPTH);
        if (m_active) begin
            m_fc++;
            if (m_fc == m_len) begin
                if (had_word) start_frame();
                else          m_active = 1'b0;
            end
        end else if (had_word) begin
            start_frame();
        end
        if (do_push) mq.push_back(s_data);
    endtask

    task automatic compare_outputs();
        bit exp_tx;
        exp_tx = m_active ? fbits[m_fc / m_eff] : 1'b1;
        check("tx", tx, exp_tx);
        check("busy", busy, m_active);
        check("fifo_count", fifo_count, mq.size());
        check("s_ready", s_ready, mq.size() != FIFO_DEPTH);
    endtask

    // Advance one clock cycle: update the model at the edge, then check the outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic rand_cfg();
        case ($urandom_range(0, 5))
            0: baud_div = 16'd0;
            1: baud_div = 16'd1;
            2: baud_div = 16'd2;
            3: baud_div = 16'd3;
            4: baud_div = 16'd4;
            default: baud_div = 16'd8;
        endcase
        parity_mode = 2'($urandom_range(0, 3));
        two_stop    = 1'($urandom_range(0, 1));
    endtask

    int busy_cycles;
    int guard;

    initial begin
        rst_n       = 1'b0;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_active    = 1'b0;
        m_fc        = 0;
        m_eff       = 2;
        m_len       = 0;
        #12;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", s_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Send a single 0x55 with 8N1 at 4 cycles per bit. busy must be high for exactly 40 cycles.
        s_valid = 1'b1;
        s_data  = 8'h55;
        step();
        @(negedge clk);
        s_valid = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        check("busy_len_8n1", busy_cycles, 40);

        // Random traffic. Load and configuration change between phases, and the configuration also changes mid-frame.
        for (int p = 0; p < 8; p++) begin
            rand_cfg();
            for (int c = 0; c < 1500; c++) begin
                case (p % 4)
                    0: s_valid = 1'b1;
                    1: s_valid = ($urandom_range(0, 3) == 0);
                    2: s_valid = ($urandom_range(0, 40) == 0);
                    default: s_valid = ($urandom_range(0, 1) == 0);
                endcase
                s_data = DATA_BITS'($urandom);
                if ($urandom_range(0, 63) == 0) rand_cfg();
                step();
                @(negedge clk);
            end
        end

        // Let the FIFO drain completely.
        s_valid = 1'b0;
        guard   = 0;
        while ((m_active || mq.size() != 0) && guard < 8000) begin
            step();
            @(negedge clk);
            guard++;
        end
        check("drain_done", (m_active || mq.size() != 0), 0);

        // Queue four words and run into the data bits of the first frame.
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_BITS'($urandom);
            step();
            @(negedge clk);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
        end
        check("pre_rst_count", fifo_count, 3);

        // Assert reset mid-frame. The outputs must change without waiting for a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx", tx, 1);
        check("arst_busy", busy, 0);
        check("arst_count", fifo_count, 0);
        check("arst_ready", s_ready, 1);
        mq.delete();
        m_active = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // After reset is released, tx must stay high while nothing is pushed.
        for (int i = 0; i < 30; i++) begin
            step();
            @(negedge clk);
        end

        // Push one word after reset to confirm the block still transmits.
        s_valid = 1'b1;
        s_data  = 8'hA3;
        rand_cfg();
        step();
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
